// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters for out-of-order producers,
// with write-through busy flags and a decode-stage stall request.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_dst,
  output logic          iss_ready,
  input  logic          cmp_valid,
  input  logic [AW-1:0] cmp_dst,
  input  logic [AW-1:0] rd_a1,
  input  logic [AW-1:0] rd_a2,
  input  logic          use1,
  input  logic          use2,
  output logic          busy1,
  output logic          busy2,
  output logic          stall,
  output logic          pending_any,
  output logic          err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [AW-1:0]    REG_ZERO = {AW{1'b0}};

  logic [CNT_W-1:0] cnt_r     [NREG];
  logic [CNT_W-1:0] cnt_nxt_s [NREG];
  logic             err_r;

  logic             iss_acc_s;
  logic             cmp_nz_s;
  logic             cmp_err_s;
  logic [CNT_W-1:0] cnt_iss_s;
  logic [CNT_W-1:0] cnt_cmp_s;
  logic [CNT_W-1:0] cnt_a1_s;
  logic [CNT_W-1:0] cnt_a2_s;

  assign cnt_iss_s = cnt_r[iss_dst];
  assign cnt_cmp_s = cnt_r[cmp_dst];
  assign cnt_a1_s  = cnt_r[rd_a1];
  assign cnt_a2_s  = cnt_r[rd_a2];

  // Issue acceptance, retire classification and decode-side busy/stall.
  always_comb begin
    iss_ready = (iss_dst == REG_ZERO) | (cnt_iss_s != CNT_MAX);
    iss_acc_s = iss_valid & iss_ready & (iss_dst != REG_ZERO);
    cmp_nz_s  = cmp_valid & (cmp_dst != REG_ZERO);
    cmp_err_s = cmp_nz_s & (cnt_cmp_s == CNT_ZERO);
    // A final retire in this cycle is visible immediately, like the regfile bypass.
    busy1 = (rd_a1 != REG_ZERO) & (cnt_a1_s != CNT_ZERO)
          & ~(cmp_valid & (cmp_dst == rd_a1) & (cnt_a1_s == CNT_ONE));
    busy2 = (rd_a2 != REG_ZERO) & (cnt_a2_s != CNT_ZERO)
          & ~(cmp_valid & (cmp_dst == rd_a2) & (cnt_a2_s == CNT_ONE));
    stall = (busy1 & use1) | (busy2 & use2);
  end

  // Next counter values; an erroneous retire does not decrement, so same-register
  // issue+retire on a zero counter leaves it at one.
  always_comb begin
    pending_any = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      pending_any  = pending_any | (cnt_r[i] != CNT_ZERO);
      cnt_nxt_s[i] = (i == 0) ? CNT_ZERO :
                     cnt_r[i]
                     + CNT_W'(iss_acc_s && (iss_dst == AW'(i)))
                     - CNT_W'(cmp_nz_s && (cmp_dst == AW'(i)) && (cnt_r[i] != CNT_ZERO));
    end
  end

  // State update with reset > flush > issue/retire; err is sticky across flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt_r[i] <= CNT_ZERO;
      err_r <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) cnt_r[i] <= CNT_ZERO;
      err_r <= err_r;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_r[i] <= cnt_nxt_s[i];
      err_r <= err_r | cmp_err_s;
    end
  end

  assign err = err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: each step pushes the expected output vector
// {iss_ready, busy1, busy2, stall, pending_any, err} and pops it against the DUT.
module tb_reg_scoreboard;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       iss_valid;
  logic [4:0] iss_dst;
  logic       iss_ready;
  logic       cmp_valid;
  logic [4:0] cmp_dst;
  logic [4:0] rd_a1;
  logic [4:0] rd_a2;
  logic       use1;
  logic       use2;
  logic       busy1;
  logic       busy2;
  logic       stall;
  logic       pending_any;
  logic       err;

  typedef struct {
    string      tag;
    logic [5:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  reg_scoreboard #(.NREG(32), .AW(5), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(iss_ready),
    .cmp_valid(cmp_valid), .cmp_dst(cmp_dst),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .use1(use1), .use2(use2),
    .busy1(busy1), .busy2(busy2), .stall(stall),
    .pending_any(pending_any), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs are set at a negedge; outputs are compared 2 time units later, well before posedge.
  task automatic step(input string tag, input logic [5:0] e);
    exp_t       x;
    logic [5:0] obs;
    exp_q.push_back('{tag, e});
    #2;
    x     = exp_q.pop_front();
    obs   = {iss_ready, busy1, busy2, stall, pending_any, err};
    tests = tests + 1;
    assert (obs === x.vec)
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%b expected=%b (rdy,b1,b2,stall,pend,err)", x.tag, obs, x.vec);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic [4:0] id, input logic cv, input logic [4:0] cd);
    iss_valid = iv;
    iss_dst   = id;
    cmp_valid = cv;
    cmp_dst   = cd;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    rd_a1 = 5'd0; rd_a2 = 5'd0; use1 = 1'b0; use2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset / idle
    drive(1'b0, 5'd5, 1'b0, 5'd0);
    step("reset_idle", 6'b100000);

    // Single issue/retire on $8 with write-through
    rd_a1 = 5'd8; use1 = 1'b1;
    drive(1'b1, 5'd8, 1'b0, 5'd0); step("r8_issue_c0", 6'b100000);
    drive(1'b0, 5'd8, 1'b0, 5'd0); step("r8_busy_c1", 6'b110110);
    step("r8_busy_c2", 6'b110110);
    drive(1'b0, 5'd8, 1'b1, 5'd8); step("r8_retire_wt", 6'b100010);
    drive(1'b0, 5'd8, 1'b0, 5'd0); step("r8_pend_clear", 6'b100000);

    // Saturate $3, refused fourth issue, three retires
    rd_a1 = 5'd3;
    drive(1'b1, 5'd3, 1'b0, 5'd0); step("r3_iss1", 6'b100000);
    step("r3_iss2", 6'b110110);
    step("r3_iss3", 6'b110110);
    step("r3_full_refuse", 6'b010110);
    drive(1'b0, 5'd3, 1'b1, 5'd3); step("r3_ret1_notready", 6'b010110);
    step("r3_ret2", 6'b110110);
    step("r3_ret3_wt", 6'b100010);
    drive(1'b0, 5'd3, 1'b0, 5'd0); step("r3_empty", 6'b100000);

    // Same-cycle issue+retire on $9, then underflow error
    rd_a1 = 5'd9;
    drive(1'b1, 5'd9, 1'b0, 5'd0); step("r9_issue", 6'b100000);
    drive(1'b1, 5'd9, 1'b1, 5'd9); step("r9_iss_ret_same", 6'b100010);
    drive(1'b0, 5'd9, 1'b0, 5'd0); step("r9_still_busy", 6'b110110);
    drive(1'b0, 5'd9, 1'b1, 5'd9); step("r9_retire_wt", 6'b100010);
    step("r9_underflow", 6'b100000);
    drive(1'b0, 5'd9, 1'b0, 5'd0); step("r9_err_set", 6'b100001);

    // Register 0 is never pending and never stalls
    rd_a1 = 5'd0;
    drive(1'b1, 5'd0, 1'b0, 5'd0); step("r0_issue", 6'b100001);
    drive(1'b0, 5'd0, 1'b0, 5'd0); step("r0_no_pend", 6'b100001);

    // Flush with $4 and $7 pending, discarding an issue to $10
    rd_a1 = 5'd4; rd_a2 = 5'd7; use2 = 1'b1;
    drive(1'b1, 5'd4, 1'b0, 5'd0); step("fl_iss4", 6'b100001);
    drive(1'b1, 5'd7, 1'b0, 5'd0); step("fl_iss7", 6'b110111);
    flush = 1'b1;
    drive(1'b1, 5'd10, 1'b0, 5'd0); step("fl_flush", 6'b111111);
    flush = 1'b0;
    drive(1'b0, 5'd10, 1'b0, 5'd0); step("fl_cleared", 6'b100001);
    rd_a1 = 5'd10; step("fl_r10_dropped", 6'b100001);

    // Mid-sequence reset clears err and pending work
    drive(1'b1, 5'd10, 1'b0, 5'd0); step("rs_iss10", 6'b100001);
    reset = 1'b1;
    drive(1'b0, 5'd10, 1'b0, 5'd0); step("rs_assert", 6'b110111);
    reset = 1'b0; step("rs_cleared", 6'b100000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
